// File: rtl/llc_req_in_queue.sv
// llc_req_in_queue
// Elastic in-order request FIFO between the NoC request plane and the LLC input
// decoder. Requests enter when llc_req_in_valid meets the registered
// llc_req_in_ready. The oldest entry is presented on llc_req_in_valid_int and
// req_in_*. The decoder pops it with llc_req_in_ready_int.
// All status outputs come from registers, so NoC-side ready never depends
// combinationally on decoder-side ready.
module llc_req_in_queue #(
  parameter int DEPTH          = 4,
  parameter int MSG_W          = 5,
  parameter int ID_W           = 6,
  parameter int LINE_ADDR_BITS = 32,
  parameter int AF_LEVEL       = DEPTH - 1,
  localparam int PTR_W         = $clog2(DEPTH),
  localparam int OCC_W         = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      llc_req_in_valid,
  output logic                      llc_req_in_ready,
  input  logic [MSG_W-1:0]          llc_req_in_msg,
  input  logic [LINE_ADDR_BITS-1:0] llc_req_in_addr,
  input  logic [ID_W-1:0]           llc_req_in_id,
  output logic                      llc_req_in_valid_int,
  input  logic                      llc_req_in_ready_int,
  output logic [MSG_W-1:0]          req_in_msg,
  output logic [LINE_ADDR_BITS-1:0] req_in_addr,
  output logic [ID_W-1:0]           req_in_id,
  output logic [OCC_W-1:0]          occupancy,
  output logic                      almost_full
);

  localparam int ENTRY_W = MSG_W + LINE_ADDR_BITS + ID_W;

  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_AF   = OCC_W'(AF_LEVEL);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_ZERO = OCC_W'(0);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);

  // Entry storage is deliberately not reset; occupancy alone defines validity
  logic [ENTRY_W-1:0] r_mem [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_occ;
  logic             r_ready;
  logic             r_valid_int;
  logic             r_af;

  logic             w_push;
  logic             w_pop;
  logic [OCC_W-1:0] w_occ_nxt;
  logic [PTR_W-1:0] w_wr_ptr_nxt;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [ENTRY_W-1:0] w_head;

  assign w_push = llc_req_in_valid && r_ready;
  assign w_pop  = r_valid_int && llc_req_in_ready_int;
  assign w_head = r_mem[r_rd_ptr];

  // Next occupancy and pointer values from push/pop; pointers wrap by explicit compare
  always_comb begin
    w_occ_nxt    = r_occ;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    case ({w_push, w_pop})
      2'b10:   w_occ_nxt = r_occ + OCC_ONE;
      2'b01:   w_occ_nxt = r_occ - OCC_ONE;
      default: w_occ_nxt = r_occ;
    endcase
    if (w_push) begin
      if (r_wr_ptr == PTR_LAST) begin
        w_wr_ptr_nxt = PTR_ZERO;
      end else begin
        w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
      end
    end else begin
      w_wr_ptr_nxt = r_wr_ptr;
    end
    if (w_pop) begin
      if (r_rd_ptr == PTR_LAST) begin
        w_rd_ptr_nxt = PTR_ZERO;
      end else begin
        w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
      end
    end else begin
      w_rd_ptr_nxt = r_rd_ptr;
    end
  end

  // Write the accepted request into the slot at the write pointer
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {llc_req_in_msg, llc_req_in_addr, llc_req_in_id};
    end
  end

  // Pointers, occupancy and registered status flags; ready stays low while in reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr    <= PTR_ZERO;
      r_rd_ptr    <= PTR_ZERO;
      r_occ       <= OCC_ZERO;
      r_ready     <= 1'b0;
      r_valid_int <= 1'b0;
      r_af        <= 1'b0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_occ       <= w_occ_nxt;
      r_ready     <= (w_occ_nxt != OCC_FULL);
      r_valid_int <= (w_occ_nxt != OCC_ZERO);
      r_af        <= (w_occ_nxt >= OCC_AF);
    end
  end

  // Head fields are forced to zero while the queue is empty so that stale storage never leaks out
  always_comb begin
    if (r_valid_int) begin
      req_in_msg  = w_head[ENTRY_W-1 -: MSG_W];
      req_in_addr = w_head[ID_W +: LINE_ADDR_BITS];
      req_in_id   = w_head[ID_W-1:0];
    end else begin
      req_in_msg  = {MSG_W{1'b0}};
      req_in_addr = {LINE_ADDR_BITS{1'b0}};
      req_in_id   = {ID_W{1'b0}};
    end
  end

  assign llc_req_in_ready     = r_ready;
  assign llc_req_in_valid_int = r_valid_int;
  assign occupancy            = r_occ;
  assign almost_full          = r_af;

endmodule

// File: tb/tb_llc_req_in_queue.sv
// Directed testbench for llc_req_in_queue (DEPTH=4, AF_LEVEL=3).
module tb_llc_req_in_queue;

  logic        clk;
  logic        rst;
  logic        llc_req_in_valid;
  logic        llc_req_in_ready;
  logic [4:0]  llc_req_in_msg;
  logic [31:0] llc_req_in_addr;
  logic [5:0]  llc_req_in_id;
  logic        llc_req_in_valid_int;
  logic        llc_req_in_ready_int;
  logic [4:0]  req_in_msg;
  logic [31:0] req_in_addr;
  logic [5:0]  req_in_id;
  logic [2:0]  occupancy;
  logic        almost_full;

  int checks = 0;
  int errors = 0;

  llc_req_in_queue #(
    .DEPTH(4), .MSG_W(5), .ID_W(6), .LINE_ADDR_BITS(32), .AF_LEVEL(3)
  ) dut (
    .clk(clk), .rst(rst),
    .llc_req_in_valid(llc_req_in_valid), .llc_req_in_ready(llc_req_in_ready),
    .llc_req_in_msg(llc_req_in_msg), .llc_req_in_addr(llc_req_in_addr),
    .llc_req_in_id(llc_req_in_id), .llc_req_in_valid_int(llc_req_in_valid_int),
    .llc_req_in_ready_int(llc_req_in_ready_int), .req_in_msg(req_in_msg),
    .req_in_addr(req_in_addr), .req_in_id(req_in_id),
    .occupancy(occupancy), .almost_full(almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] m, input logic [31:0] a, input logic [5:0] i);
    llc_req_in_valid = v;
    llc_req_in_msg   = m;
    llc_req_in_addr  = a;
    llc_req_in_id    = i;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 6'd0);
    llc_req_in_ready_int = 1'b0;
    step();
    step();
    checks++; if (llc_req_in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b exp 0", llc_req_in_ready); end
    checks++; if (llc_req_in_valid_int !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", llc_req_in_valid_int); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got %0b exp 0", almost_full); end
    checks++; if (req_in_addr !== 32'h0) begin errors++; $display("FAIL reset_head got %h exp 0", req_in_addr); end
    rst = 1'b1;
    step();
    checks++; if (llc_req_in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %0b exp 1", llc_req_in_ready); end
  endtask

  task automatic test_push_latency();
    drive(1'b1, 5'd1, 32'h1000, 6'd3);
    checks++; if (llc_req_in_valid_int !== 1'b0) begin errors++; $display("FAIL push_same_cycle got %0b exp 0", llc_req_in_valid_int); end
    step();
    drive(1'b0, 5'd0, 32'd0, 6'd0);
    checks++; if (llc_req_in_valid_int !== 1'b1) begin errors++; $display("FAIL push_next_valid got %0b exp 1", llc_req_in_valid_int); end
    checks++; if (req_in_addr !== 32'h1000) begin errors++; $display("FAIL push_addr got %h exp 00001000", req_in_addr); end
    checks++; if (req_in_id !== 6'd3) begin errors++; $display("FAIL push_id got %0d exp 3", req_in_id); end
    checks++; if (req_in_msg !== 5'd1) begin errors++; $display("FAIL push_msg got %0d exp 1", req_in_msg); end
    checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL push_occ got %0d exp 1", occupancy); end
  endtask

  task automatic test_fill();
    logic [31:0] addrs [3];
    logic [2:0]  exp_occ [3];
    logic        exp_af [3];
    logic        exp_rdy [3];
    addrs   = '{32'h2000, 32'h3000, 32'h4000};
    exp_occ = '{3'd2, 3'd3, 3'd4};
    exp_af  = '{1'b0, 1'b1, 1'b1};
    exp_rdy = '{1'b1, 1'b1, 1'b0};
    llc_req_in_ready_int = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'(k + 2), addrs[k], 6'(k + 4));
      step();
      checks++; if (occupancy !== exp_occ[k]) begin errors++; $display("FAIL fill_occ[%0d] got %0d exp %0d", k, occupancy, exp_occ[k]); end
      checks++; if (almost_full !== exp_af[k]) begin errors++; $display("FAIL fill_af[%0d] got %0b exp %0b", k, almost_full, exp_af[k]); end
      checks++; if (llc_req_in_ready !== exp_rdy[k]) begin errors++; $display("FAIL fill_ready[%0d] got %0b exp %0b", k, llc_req_in_ready, exp_rdy[k]); end
    end
    drive(1'b1, 5'd9, 32'h9999, 6'd9);
    step();
    drive(1'b0, 5'd0, 32'd0, 6'd0);
    checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL full_push_ignored got %0d exp 4", occupancy); end
    checks++; if (req_in_addr !== 32'h1000) begin errors++; $display("FAIL full_head_stable got %h exp 00001000", req_in_addr); end
  endtask

  task automatic test_pop_from_full();
    logic [31:0] order [4];
    order = '{32'h2000, 32'h3000, 32'h4000, 32'h5000};
    llc_req_in_ready_int = 1'b1;
    step();
    llc_req_in_ready_int = 1'b0;
    checks++; if (llc_req_in_ready !== 1'b1) begin errors++; $display("FAIL pop_full_ready got %0b exp 1", llc_req_in_ready); end
    checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL pop_full_occ got %0d exp 3", occupancy); end
    drive(1'b1, 5'd5, 32'h5000, 6'd7);
    step();
    drive(1'b0, 5'd0, 32'd0, 6'd0);
    checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL refill_occ got %0d exp 4", occupancy); end
    llc_req_in_ready_int = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (req_in_addr !== order[k]) begin errors++; $display("FAIL order[%0d] got %h exp %h", k, req_in_addr, order[k]); end
      step();
    end
    llc_req_in_ready_int = 1'b0;
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL drain_occ got %0d exp 0", occupancy); end
    checks++; if (llc_req_in_valid_int !== 1'b0) begin errors++; $display("FAIL drain_valid got %0b exp 0", llc_req_in_valid_int); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q [$];
    logic [31:0] nxt;
    drive(1'b1, 5'd3, 32'hA000, 6'd10);
    step();
    drive(1'b1, 5'd4, 32'hB000, 6'd11);
    step();
    exp_q.push_back(32'hA000);
    exp_q.push_back(32'hB000);
    checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL b2b_start_occ got %0d exp 2", occupancy); end
    llc_req_in_ready_int = 1'b1;
    for (int k = 0; k < 20; k++) begin
      nxt = 32'hC000 + 32'(k);
      drive(1'b1, 5'(k), nxt, 6'(k));
      checks++; if (req_in_addr !== exp_q[0]) begin errors++; $display("FAIL b2b_head[%0d] got %h exp %h", k, req_in_addr, exp_q[0]); end
      step();
      void'(exp_q.pop_front());
      exp_q.push_back(nxt);
      checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL b2b_occ[%0d] got %0d exp 2", k, occupancy); end
    end
    drive(1'b0, 5'd0, 32'd0, 6'd0);
    for (int k = 0; k < 2; k++) begin
      checks++; if (req_in_addr !== exp_q[k]) begin errors++; $display("FAIL b2b_tail[%0d] got %h exp %h", k, req_in_addr, exp_q[k]); end
      step();
    end
    llc_req_in_ready_int = 1'b0;
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL b2b_end_occ got %0d exp 0", occupancy); end
  endtask

  task automatic test_empty_pop();
    llc_req_in_ready_int = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL empty_occ[%0d] got %0d exp 0", k, occupancy); end
      checks++; if (llc_req_in_valid_int !== 1'b0) begin errors++; $display("FAIL empty_valid[%0d] got %0b exp 0", k, llc_req_in_valid_int); end
    end
    llc_req_in_ready_int = 1'b0;
    checks++; if (llc_req_in_ready !== 1'b1) begin errors++; $display("FAIL empty_ready got %0b exp 1", llc_req_in_ready); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'(k), 32'h7000 + 32'(k), 6'(k));
      step();
    end
    drive(1'b0, 5'd0, 32'd0, 6'd0);
    checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL mid_pre_occ got %0d exp 3", occupancy); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL mid_rst_occ got %0d exp 0", occupancy); end
    checks++; if (llc_req_in_valid_int !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %0b exp 0", llc_req_in_valid_int); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL mid_rst_af got %0b exp 0", almost_full); end
    checks++; if (llc_req_in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %0b exp 0", llc_req_in_ready); end
    step();
    rst = 1'b1;
    step();
    drive(1'b1, 5'd6, 32'h5A00, 6'd33);
    step();
    drive(1'b0, 5'd0, 32'd0, 6'd0);
    checks++; if (dut.r_rd_ptr !== 2'd0) begin errors++; $display("FAIL mid_rd_ptr got %0d exp 0", dut.r_rd_ptr); end
    checks++; if (dut.r_wr_ptr !== 2'd1) begin errors++; $display("FAIL mid_wr_ptr got %0d exp 1", dut.r_wr_ptr); end
    checks++; if (req_in_addr !== 32'h5A00) begin errors++; $display("FAIL mid_head got %h exp 00005a00", req_in_addr); end
    checks++; if (req_in_id !== 6'd33) begin errors++; $display("FAIL mid_id got %0d exp 33", req_in_id); end
    checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL mid_occ got %0d exp 1", occupancy); end
  endtask

  initial begin
    test_reset();
    test_push_latency();
    test_fill();
    test_pop_from_full();
    test_back_to_back();
    test_empty_pop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
